// File: rtl/spi2dac_rx.sv
// MCP4911 responder: oversamples the DAC SPI bus, deserialises 16-bit
// write frames and double-buffers them behind the LDAC strobe.
module spi2dac_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        dac_sck,
    input  logic        dac_cs,
    input  logic        dac_sdi,
    input  logic        dac_ld,
    output logic [15:0] in_reg,
    output logic [9:0]  dac_data,
    output logic        gain_x1,
    output logic        buffered,
    output logic        active,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        load
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] ld_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic                   ld_d;

    logic sck_s, cs_s, sdi_s, ld_s;
    logic sck_rise, cs_fall, cs_rise, ld_fall;

    logic [15:0] shift;
    logic [4:0]  bit_cnt;
    logic        accept;
    logic        reject;
    logic [12:0] xfer;

    // cs and ld idle high; resetting them high avoids a phantom falling edge
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sdi_sync <= '0;
            ld_sync  <= '1;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
            ld_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], dac_sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], dac_cs};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], dac_sdi};
            ld_sync  <= {ld_sync[SYNC_STAGES-2:0], dac_ld};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
            ld_d     <= ld_s;
        end
    end

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];
    assign ld_s  = ld_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign ld_fall  = ~ld_s & ld_d;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (cs_fall) state_n = SHIFT;
            SHIFT:   if (cs_rise) state_n = CHECK;
            CHECK:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Channel B writes are rejected: the 4911 has only channel A
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (state == CHECK) begin
            accept = (bit_cnt == 5'd16) && !shift[15];
            reject = (bit_cnt != 5'd0) && !accept;
        end
    end

    // A transfer coinciding with an accept takes the fresh frame
    assign xfer = accept ? shift[14:2] : in_reg[14:2];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            shift       <= '0;
            bit_cnt     <= '0;
            in_reg      <= '0;
            dac_data    <= '0;
            gain_x1     <= 1'b0;
            buffered    <= 1'b0;
            active      <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            load        <= 1'b0;
        end else begin
            frame_valid <= accept;
            frame_err   <= reject;
            load        <= ld_fall;
            if (state == IDLE && cs_fall) begin
                shift   <= '0;
                bit_cnt <= '0;
            end
            if (state == SHIFT && sck_rise) begin
                shift <= {shift[14:0], sdi_s};
                if (bit_cnt != 5'd17) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (accept) begin
                in_reg <= shift;
            end
            if (ld_fall) begin
                dac_data <= xfer[9:0];
                active   <= xfer[10];
                gain_x1  <= xfer[11];
                buffered <= xfer[12];
            end
        end
    end

endmodule

// File: tb/tb_spi2dac_rx.sv
// Scoreboard bench for spi2dac_rx: predicted frame results and LDAC
// transfers are queued at stimulus time and popped when the DUT pulses.
module tb_spi2dac_rx;

    localparam int S    = 2;
    localparam int HALF = S + 1;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        dac_sck;
    logic        dac_cs;
    logic        dac_sdi;
    logic        dac_ld;
    logic [15:0] in_reg;
    logic [9:0]  dac_data;
    logic        gain_x1;
    logic        buffered;
    logic        active;
    logic        frame_valid;
    logic        frame_err;
    logic        load;

    spi2dac_rx #(.SYNC_STAGES(S)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .dac_sck     (dac_sck),
        .dac_cs      (dac_cs),
        .dac_sdi     (dac_sdi),
        .dac_ld      (dac_ld),
        .in_reg      (in_reg),
        .dac_data    (dac_data),
        .gain_x1     (gain_x1),
        .buffered    (buffered),
        .active      (active),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .load        (load)
    );

    always #10 sysclk = ~sysclk;

    typedef struct packed {
        logic        ok;
        logic [15:0] w;
    } fexp_t;

    typedef struct packed {
        logic [9:0] d;
        logic       g;
        logic       b;
        logic       a;
    } lexp_t;

    int          checks = 0;
    int          errors = 0;
    fexp_t       fq[$];
    lexp_t       lq[$];
    logic [15:0] model_in;

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic monitor();
        fexp_t fe;
        lexp_t le;
        forever begin
            @(negedge sysclk);
            if (frame_valid || frame_err) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL frame_pulse unexpected v=%0b e=%0b in_reg=%h",
                             frame_valid, frame_err, in_reg);
                end else begin
                    fe = fq.pop_front();
                    if ({frame_valid, frame_err, in_reg} !== {fe.ok, !fe.ok, fe.w}) begin
                        errors++;
                        $display("FAIL frame v=%0b e=%0b in_reg=%h want v=%0b in_reg=%h",
                                 frame_valid, frame_err, in_reg, fe.ok, fe.w);
                    end
                end
            end
            if (load) begin
                checks++;
                if (lq.size() == 0) begin
                    errors++;
                    $display("FAIL load unexpected dac_data=%h", dac_data);
                end else begin
                    le = lq.pop_front();
                    if ({dac_data, gain_x1, buffered, active} !== le) begin
                        errors++;
                        $display("FAIL load got %h/%0b%0b%0b want %h/%0b%0b%0b",
                                 dac_data, gain_x1, buffered, active,
                                 le.d, le.g, le.b, le.a);
                    end
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((fq.size() != 0 || lq.size() != 0) && k < 60) begin
            tick(1);
            k++;
        end
        checks++;
        if (fq.size() != 0 || lq.size() != 0) begin
            errors++;
            $display("FAIL drain_%s pending frames=%0d loads=%0d want 0",
                     name, fq.size(), lq.size());
            fq.delete();
            lq.delete();
        end
    endtask

    task automatic predict(input logic [15:0] w, input int n);
        if (n == 16 && !w[15]) begin
            model_in = w;
            fq.push_back('{ok: 1'b1, w: w});
        end else if (n != 0) begin
            fq.push_back('{ok: 1'b0, w: model_in});
        end
    endtask

    task automatic push_load();
        lq.push_back('{d: model_in[11:2], g: model_in[13],
                       b: model_in[14], a: model_in[12]});
    endtask

    task automatic sck_bits(input logic [15:0] w, input int first, input int last);
        for (int i = first; i < last; i++) begin
            dac_sdi = (i < 16) ? w[15-i] : 1'b0;
            tick(HALF);
            dac_sck = 1'b1;
            tick(HALF);
            dac_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] w, input int n);
        dac_cs = 1'b0;
        tick(3);
        sck_bits(w, 0, n);
        tick(2);
        predict(w, n);
        dac_cs = 1'b1;
        tick(8);
    endtask

    task automatic ld_pulse();
        push_load();
        dac_ld = 1'b0;
        tick(4);
        dac_ld = 1'b1;
        tick(6);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        dac_cs  = 1'b1;
        dac_ld  = 1'b1;
        dac_sck = 1'b0;
        dac_sdi = 1'b0;
        model_in = '0;
        tick(3);
        checks++;
        if ({in_reg, dac_data, gain_x1, buffered, active,
             frame_valid, frame_err, load} !== 32'h0) begin
            errors++;
            $display("FAIL reset_init in_reg=%h dac_data=%h want 0", in_reg, dac_data);
        end
        reset = 1'b0;
        tick(5);
        frame(16'h7124, 16);
        ld_pulse();
        drain("preload");
        dac_cs = 1'b0;
        tick(3);
        sck_bits(16'h3FFC, 0, 7);
        reset   = 1'b1;
        dac_cs  = 1'b1;
        dac_sck = 1'b0;
        tick(2);
        checks++;
        if ({in_reg, dac_data, gain_x1, buffered, active,
             frame_valid, frame_err, load} !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid in_reg=%h dac_data=%h want 0", in_reg, dac_data);
        end
        model_in = '0;
        reset = 1'b0;
        tick(20);
        drain("after_reset");
        frame(16'h3008, 16);
        drain("reset_recover");
    endtask

    task automatic test_good();
        int k;
        dac_cs = 1'b0;
        tick(3);
        sck_bits(16'h3FFC, 0, 16);
        tick(2);
        predict(16'h3FFC, 16);
        dac_cs = 1'b1;
        k = 0;
        while (!frame_valid && k < 20) begin
            tick(1);
            k++;
        end
        checks++;
        if (k !== S + 2) begin
            errors++;
            $display("FAIL valid_latency got %0d want %0d", k, S + 2);
        end
        tick(8);
        drain("good_frame");
        push_load();
        dac_ld = 1'b0;
        k = 0;
        while (!load && k < 20) begin
            tick(1);
            k++;
        end
        checks++;
        if (k !== S + 1) begin
            errors++;
            $display("FAIL load_latency got %0d want %0d", k, S + 1);
        end
        tick(20);
        dac_ld = 1'b1;
        tick(6);
        drain("good_load");
        checks++;
        if ({dac_data, gain_x1, active, buffered} !== {10'h3FF, 3'b110}) begin
            errors++;
            $display("FAIL good_out got %h/%0b%0b%0b want 3ff/110",
                     dac_data, gain_x1, active, buffered);
        end
    endtask

    task automatic test_bad_frames();
        frame(16'h1234, 15);
        ld_pulse();
        frame(16'h1234, 18);
        ld_pulse();
        frame(16'hB004, 16);
        frame(16'h0000, 0);
        drain("bad");
        checks++;
        if (in_reg !== 16'h3FFC || dac_data !== 10'h3FF) begin
            errors++;
            $display("FAIL bad_keep in_reg=%h dac_data=%h want 3ffc/3ff", in_reg, dac_data);
        end
    endtask

    task automatic test_bypass();
        int k;
        dac_cs = 1'b0;
        tick(3);
        sck_bits(16'h3200, 0, 16);
        tick(2);
        predict(16'h3200, 16);
        push_load();
        dac_cs = 1'b1;
        tick(1);
        dac_ld = 1'b0;
        k = 0;
        while (!load && k < 20) begin
            tick(1);
            k++;
        end
        checks++;
        if (!frame_valid || dac_data !== 10'h080) begin
            errors++;
            $display("FAIL bypass valid=%0b dac_data=%h want 1/080", frame_valid, dac_data);
        end
        tick(4);
        dac_ld = 1'b1;
        tick(6);
        drain("bypass");
    endtask

    task automatic test_back_to_back();
        frame(16'h3004, 16);
        frame(16'h3008, 16);
        drain("b2b_frames");
        checks++;
        if (dac_data !== 10'h080) begin
            errors++;
            $display("FAIL b2b_hold dac_data=%h want 080", dac_data);
        end
        ld_pulse();
        drain("b2b_load");
        checks++;
        if (dac_data !== 10'h002) begin
            errors++;
            $display("FAIL b2b_out dac_data=%h want 002", dac_data);
        end
    endtask

    task automatic test_mid_frame_ld();
        dac_cs = 1'b0;
        tick(3);
        sck_bits(16'h3A5C, 0, 8);
        ld_pulse();
        sck_bits(16'h3A5C, 8, 16);
        tick(2);
        predict(16'h3A5C, 16);
        dac_cs = 1'b1;
        tick(8);
        drain("mid_ld");
        checks++;
        if (in_reg !== 16'h3A5C || dac_data !== 10'h002) begin
            errors++;
            $display("FAIL mid_ld in_reg=%h dac_data=%h want 3a5c/002", in_reg, dac_data);
        end
    endtask

    task automatic test_loopback();
        logic [9:0]  v;
        logic [15:0] w;
        for (int i = 0; i < 300; i++) begin
            v = 10'(i * 37);
            w = {4'b0011, v, 2'b00};
            frame(w, 16);
            ld_pulse();
            if (i % 25 == 24) drain("loopback");
        end
        drain("loopback_end");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_good();
        test_bad_frames();
        test_bypass();
        test_back_to_back();
        test_mid_frame_ld();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
